ins_mem_loader: RTL and testbench

//  Write-side companion of the instruction memory: drives port A (clka/ena/wea/addra/dina)
//  of BRAM_INS, whose port B is read by the decoder via pc. Accepts a host byte stream
//  (valid/ready), assembles little-endian INS_WIDTH-bit instructions, writes them from

---
 rtl/ins_mem_loader_if.sv | 24 ++
 rtl/ins_mem_loader.sv | 162 ++++++++++++++++
 tb/tb_ins_mem_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_mem_loader_if.sv
// rtl/ins_mem_loader_if.sv - host byte stream and BRAM port A bundle for ins_mem_loader
interface ins_mem_loader_if #(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int INS_WIDTH      = 64
);
    logic                      s_valid;
    logic [7:0]                s_data;
    logic                      s_ready;
    logic                      ins_ena;
    logic                      ins_wea;
    logic [INS_ADDR_WIDTH-1:0] ins_addra;
    logic [INS_WIDTH-1:0]      ins_dina;

    // master: host byte source plus the BRAM write port it feeds
    modport master (
        output s_valid, s_data,
        input  s_ready, ins_ena, ins_wea, ins_addra, ins_dina
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, ins_ena, ins_wea, ins_addra, ins_dina
    );
endinterface

// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - loads a length-prefixed byte stream into instruction BRAM port A
module ins_mem_loader #(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int INS_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    ins_mem_loader_if.slave         bus,
    output logic [INS_ADDR_WIDTH:0] ins_count,
    output logic                    core_run,
    output logic                    load_err
);
    localparam int WB = INS_WIDTH / 8;
    localparam int BW = (WB > 1) ? $clog2(WB) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [BW-1:0] BYTE_LAST = BW'(WB - 1);
    localparam logic [16:0]   DEPTH     = 17'(2 ** INS_ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t                  state_q;
    logic                    s_ready_q;
    logic                    wea_q;
    logic                    core_run_q;
    logic                    load_err_q;
    logic [15:0]             len_q;
    logic [BW-1:0]           byte_q;
    logic [TW-1:0]           idle_q;
    logic [INS_ADDR_WIDTH:0] cnt_q;
    logic [INS_WIDTH-1:0]    shift_q;

    logic                    xfer;
    logic                    timeout_hit;
    logic [15:0]             len_d;
    logic [INS_ADDR_WIDTH:0] cnt_d;
    logic                    last_word;

    always_comb begin
        xfer        = bus.s_valid && s_ready_q;
        timeout_hit = (TIMEOUT_CYCLES != 0) && !xfer && (idle_q == IDLE_LAST);
        len_d       = {bus.s_data, len_q[7:0]};
        cnt_d       = cnt_q + 1'b1;
        last_word   = (17'(cnt_d) == {1'b0, len_q});
    end

    // cnt_q is both the word index (write address) and the running instruction count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            s_ready_q  <= 1'b0;
            wea_q      <= 1'b0;
            core_run_q <= 1'b0;
            load_err_q <= 1'b0;
            len_q      <= '0;
            byte_q     <= '0;
            idle_q     <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
        end else begin
            wea_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_LEN_LO;
                        s_ready_q  <= 1'b1;
                        cnt_q      <= '0;
                        byte_q     <= '0;
                        idle_q     <= '0;
                        core_run_q <= 1'b0;
                        load_err_q <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= bus.s_data;
                        idle_q     <= '0;
                        state_q    <= S_LEN_HI;
                    end else if (timeout_hit) begin
                        state_q    <= S_ERR;
                        s_ready_q  <= 1'b0;
                        load_err_q <= 1'b1;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q  <= len_d;
                        idle_q <= '0;
                        if (len_d == 16'd0) begin
                            state_q    <= S_DONE;
                            s_ready_q  <= 1'b0;
                            core_run_q <= 1'b1;
                        end else if ({1'b0, len_d} > DEPTH) begin
                            state_q    <= S_ERR;
                            s_ready_q  <= 1'b0;
                            load_err_q <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else if (timeout_hit) begin
                        state_q    <= S_ERR;
                        s_ready_q  <= 1'b0;
                        load_err_q <= 1'b1;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        shift_q[8*byte_q +: 8] <= bus.s_data;
                        idle_q                 <= '0;
                        if (byte_q == BYTE_LAST) begin
                            byte_q    <= '0;
                            state_q   <= S_WRITE;
                            s_ready_q <= 1'b0;
                            wea_q     <= 1'b1;
                        end else begin
                            byte_q <= byte_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_q    <= S_ERR;
                        s_ready_q  <= 1'b0;
                        load_err_q <= 1'b1;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    cnt_q  <= cnt_d;
                    idle_q <= '0;
                    if (last_word) begin
                        state_q    <= S_DONE;
                        core_run_q <= 1'b1;
                    end else begin
                        state_q   <= S_DATA;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // shift_q holds the complete word during WRITE, so it doubles as the write data
    assign bus.s_ready   = s_ready_q;
    assign bus.ins_wea   = wea_q;
    assign bus.ins_ena   = wea_q;
    assign bus.ins_addra = cnt_q[INS_ADDR_WIDTH-1:0];
    assign bus.ins_dina  = shift_q;
    assign ins_count     = cnt_q;
    assign core_run      = core_run_q;
    assign load_err      = load_err_q;
endmodule

// File: tb/tb_ins_mem_loader.sv
// tb/tb_ins_mem_loader.sv - scoreboard bench for ins_mem_loader with random program loads
module tb_ins_mem_loader;
    localparam int AW = 8;
    localparam int W  = 64;
    localparam int WB = W / 8;
    localparam int TO = 40;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   ins_count;
    logic          core_run;
    logic          load_err;

    ins_mem_loader_if #(.INS_ADDR_WIDTH(AW), .INS_WIDTH(W)) bus ();

    ins_mem_loader #(.INS_ADDR_WIDTH(AW), .INS_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .bus       (bus),
        .ins_count (ins_count),
        .core_run  (core_run),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        bit            last;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  streaming = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every BRAM write must match the next expected word in order
    always @(negedge clk) begin
        if (rstn) begin
            if (streaming)
                check("ready_only_low_in_write", bus.s_ready ^ bus.ins_wea, 1);
            if (bus.ins_wea) begin
                check("ena_eq_wea", bus.ins_ena, 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h want no write", bus.ins_addra, bus.ins_dina);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", bus.ins_addra, mon_e.addr);
                    check("write_data", bus.ins_dina, mon_e.data);
                    if (mon_e.last) streaming = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.s_ready;
        end
        tick();
        check("byte_accepted", ok, 1);
    endtask

    // Reference: word i = sum of byte[i*WB+k] << 8k; expected writes queued in address order
    task automatic load(input int n, input int gap_max, input bit pulses, input bit strm, input int max_bytes);
        logic [W-1:0] w;
        logic [7:0]   b;
        int           nb = 0;
        pulse_start();
        if (strm) streaming = 1'b1;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int k = 0; k < WB; k++) begin
                if (nb == max_bytes) begin
                    bus.s_valid = 1'b0;
                    return;
                end
                b = 8'($urandom);
                w = w | (W'(b) << (8 * k));
                if (k == WB - 1) exp_q.push_back('{addr: AW'(i), data: w, last: (i == n - 1)});
                if (gap_max > 0) begin
                    repeat ($urandom_range(gap_max, 0)) begin
                        bus.s_valid = 1'b0;
                        tick();
                    end
                end
                if (pulses && (nb == 100 || nb == 1000)) start = 1'b1;
                send_byte(b);
                start = 1'b0;
                nb++;
            end
        end
    endtask

    task automatic wait_last(input int n);
        bit seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (bus.ins_wea && bus.ins_addra == AW'(n - 1)) begin
                seen = 1'b1;
                check("run_low_during_last_write", core_run, 0);
            end
        end
        check("last_write_seen", seen, 1);
        @(negedge clk);
        check("core_run_after_load", core_run, 1);
        check("ins_count_after_load", ins_count, n);
        check("ready_low_in_done", bus.s_ready, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        bus.s_valid = 1'b0;
        tick();
    endtask

    initial begin
        int at;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_wea", bus.ins_wea, 0);
        check("rst_core_run", core_run, 0);
        check("rst_load_err", load_err, 0);
        check("rst_ins_count", ins_count, 0);
        rstn = 1'b1;
        tick();

        // Fixed two-word program
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back('{addr: 8'h00, data: 64'h0807060504030201, last: 1'b0});
        exp_q.push_back('{addr: 8'h01, data: 64'h1817161514131211, last: 1'b1});
        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        for (int k = 17; k <= 24; k++) send_byte(8'(k));
        wait_last(2);
        bus.s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_byte_refused", bus.s_ready, 0);
        end
        tick();
        bus.s_valid = 1'b0;
        check("count_kept_in_done", ins_count, 2);

        // Empty program
        pulse_start();
        @(negedge clk);
        check("run_drops_after_start", core_run, 0);
        tick();
        send_byte(8'h00);
        send_byte(8'h00);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("empty_core_run", core_run, 1);
        check("empty_count", ins_count, 0);
        check("empty_no_err", load_err, 0);
        tick();

        // Oversize length 257
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("oversize_err", load_err, 1);
        check("oversize_ready", bus.s_ready, 0);
        check("oversize_run", core_run, 0);
        check("oversize_count", ins_count, 0);
        tick();

        // Timeout mid-word, then full reload
        pulse_start();
        @(negedge clk);
        check("start_clears_err", load_err, 0);
        tick();
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (3) send_byte(8'($urandom));
        bus.s_valid = 1'b0;
        at = 0;
        for (int c = 1; c <= TO + 10 && at == 0; c++) begin
            @(negedge clk);
            if (load_err) at = c;
        end
        check("timeout_latency", at, TO + 1);
        check("timeout_count", ins_count, 0);
        check("timeout_run", core_run, 0);
        check("timeout_ready", bus.s_ready, 0);
        tick();
        pulse_start();
        @(negedge clk);
        check("reload_clears_err", load_err, 0);
        tick();
        load(1, 2, 1'b0, 1'b0, -1);
        wait_last(1);

        // Random short programs with random byte gaps
        repeat (4) begin
            at = $urandom_range(6, 1);
            load(at, 3, 1'b0, 1'b0, -1);
            wait_last(at);
        end

        // Full depth, back-to-back bytes, ignored start pulses
        load(256, 0, 1'b1, 1'b1, -1);
        wait_last(256);
        check("stream_window_closed", streaming, 0);

        // Reset in the middle of a load
        load(256, 0, 1'b0, 1'b0, 3 * WB + 4);
        rstn = 1'b0;
        #2;
        check("midrst_ready", bus.s_ready, 0);
        check("midrst_wea", bus.ins_wea, 0);
        check("midrst_run", core_run, 0);
        check("midrst_err", load_err, 0);
        check("midrst_count", ins_count, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("after_rst_idle_ready", bus.s_ready, 0);
        check("midrst_writes_done", exp_q.size(), 0);
        tick();

        load(2, 1, 1'b0, 1'b0, -1);
        wait_last(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
